// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman tree builder and its downstream code generator.
package huffman_pkg;

    localparam int NODE_W      = 13;
    localparam int WEIGHT_W    = 8;
    localparam int NUM_NODES   = 7;
    localparam int NUM_LEAVES  = 4;

    localparam logic [3:0] PARENT_ROOT = 4'hF;
    localparam logic [3:0] PARENT_NONE = 4'h0;

    // Global phase encoding on the shared state bus
    localparam logic [1:0] ST_BUILD = 2'b01;
    localparam logic [1:0] ST_CODE  = 2'b10;

    // Node record field positions
    localparam int PARENT_MSB = 12;
    localparam int PARENT_LSB = 9;
    localparam int BRANCH_BIT = 8;
    localparam int WEIGHT_MSB = 7;
    localparam int WEIGHT_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_MERGE = 2'b01,
        S_DONE  = 2'b10
    } build_fsm_t;

    // Pack parent, branch and weight into one node record
    function automatic logic [NODE_W-1:0] make_node(input logic [3:0] parent,
                                                    input logic branch,
                                                    input logic [WEIGHT_W-1:0] weight);
        return {parent, branch, weight};
    endfunction

endpackage

// File: rtl/huffman_min2.sv
// Finds the two lowest-weight active nodes; on equal weight the lower index wins.
module huffman_min2 (
    input  logic [55:0] weights_i,
    input  logic [6:0]  active_i,
    output logic [2:0]  min1_o,
    output logic [2:0]  min2_o
);

    logic [7:0] best1_s;
    logic [7:0] best2_s;
    logic       found1_s;
    logic       found2_s;

    // Two ascending scans with strict less-than so the earliest index keeps ties
    always_comb begin
        min1_o   = 3'd0;
        min2_o   = 3'd0;
        best1_s  = 8'd0;
        best2_s  = 8'd0;
        found1_s = 1'b0;
        found2_s = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (active_i[i] && (!found1_s || (weights_i[i*8 +: 8] < best1_s))) begin
                found1_s = 1'b1;
                best1_s  = weights_i[i*8 +: 8];
                min1_o   = 3'(i);
            end else begin
                found1_s = found1_s;
            end
        end
        for (int i = 0; i < 7; i++) begin
            if (active_i[i] && (3'(i) != min1_o) &&
                (!found2_s || (weights_i[i*8 +: 8] < best2_s))) begin
                found2_s = 1'b1;
                best2_s  = weights_i[i*8 +: 8];
                min2_o   = 3'(i);
            end else begin
                found2_s = found2_s;
            end
        end
    end

endmodule

// File: rtl/build_huffman_tree.sv
// Builds the 7-node Huffman tree for four symbols, one merge per clock.
module build_huffman_tree
    import huffman_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic [1:0]  state,
    input  logic [5:0]  freq_1,
    input  logic [5:0]  freq_2,
    input  logic [5:0]  freq_3,
    input  logic [5:0]  freq_4,
    output logic [12:0] info_node_1,
    output logic [12:0] info_node_2,
    output logic [12:0] info_node_3,
    output logic [12:0] info_node_4,
    output logic [12:0] info_node_5,
    output logic [12:0] info_node_6,
    output logic [12:0] info_node_7,
    output logic        done
);

    build_fsm_t        fsm_q;
    logic [12:0]       node_q [0:6];
    logic [6:0]        active_q;
    logic [1:0]        k_q;
    logic              done_q;

    logic [55:0]       weights_s;
    logic [2:0]        min1_s;
    logic [2:0]        min2_s;
    logic [7:0]        w_min1_s;
    logic [7:0]        w_min2_s;
    logic [7:0]        sum_s;
    logic [3:0]        parent_s;
    logic [2:0]        target_s;
    logic [6:0]        active_d;

    assign weights_s = {node_q[6][WEIGHT_MSB:WEIGHT_LSB], node_q[5][WEIGHT_MSB:WEIGHT_LSB],
                        node_q[4][WEIGHT_MSB:WEIGHT_LSB], node_q[3][WEIGHT_MSB:WEIGHT_LSB],
                        node_q[2][WEIGHT_MSB:WEIGHT_LSB], node_q[1][WEIGHT_MSB:WEIGHT_LSB],
                        node_q[0][WEIGHT_MSB:WEIGHT_LSB]};

    huffman_min2 u_min2 (
        .weights_i (weights_s),
        .active_i  (active_q),
        .min1_o    (min1_s),
        .min2_o    (min2_s)
    );

    assign w_min1_s = node_q[min1_s][WEIGHT_MSB:WEIGHT_LSB];
    assign w_min2_s = node_q[min2_s][WEIGHT_MSB:WEIGHT_LSB];
    assign sum_s    = w_min1_s + w_min2_s;
    assign parent_s = 4'd5 + {2'b00, k_q};
    assign target_s = 3'd4 + {1'b0, k_q};

    // Retire both children and activate the freshly merged node
    always_comb begin
        active_d = (active_q & ~((7'b0000001 << min1_s) | (7'b0000001 << min2_s)))
                 | (7'b0000001 << target_s);
    end

    // Build FSM: load leaves, run three merges, then hold the finished tree
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 7; i++) begin
                node_q[i] <= 13'h0000;
            end
            active_q <= 7'b0000000;
            k_q      <= 2'd0;
            done_q   <= 1'b0;
            fsm_q    <= S_IDLE;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (state == ST_BUILD) begin
                        node_q[0] <= make_node(PARENT_NONE, 1'b0, {2'b00, freq_1});
                        node_q[1] <= make_node(PARENT_NONE, 1'b0, {2'b00, freq_2});
                        node_q[2] <= make_node(PARENT_NONE, 1'b0, {2'b00, freq_3});
                        node_q[3] <= make_node(PARENT_NONE, 1'b0, {2'b00, freq_4});
                        node_q[4] <= 13'h0000;
                        node_q[5] <= 13'h0000;
                        node_q[6] <= 13'h0000;
                        active_q  <= 7'b0001111;
                        k_q       <= 2'd0;
                        done_q    <= 1'b0;
                        fsm_q     <= S_MERGE;
                    end else begin
                        done_q <= 1'b0;
                    end
                end
                S_MERGE: begin
                    if (state != ST_BUILD) begin
                        // Abort: a partial tree must never reach the code phase
                        for (int i = 0; i < 7; i++) begin
                            node_q[i] <= 13'h0000;
                        end
                        active_q <= 7'b0000000;
                        k_q      <= 2'd0;
                        done_q   <= 1'b0;
                        fsm_q    <= S_IDLE;
                    end else begin
                        node_q[min1_s] <= make_node(parent_s, 1'b0, w_min1_s);
                        node_q[min2_s] <= make_node(parent_s, 1'b1, w_min2_s);
                        active_q       <= active_d;
                        if (k_q == 2'd2) begin
                            node_q[6] <= make_node(PARENT_ROOT, 1'b1, sum_s);
                            k_q       <= 2'd0;
                            done_q    <= 1'b1;
                            fsm_q     <= S_DONE;
                        end else begin
                            node_q[target_s] <= make_node(PARENT_NONE, 1'b0, sum_s);
                            k_q              <= k_q + 2'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (state != ST_BUILD) begin
                        done_q <= 1'b0;
                        fsm_q  <= S_IDLE;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    fsm_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign info_node_1 = node_q[0];
    assign info_node_2 = node_q[1];
    assign info_node_3 = node_q[2];
    assign info_node_4 = node_q[3];
    assign info_node_5 = node_q[4];
    assign info_node_6 = node_q[5];
    assign info_node_7 = node_q[6];
    assign done        = done_q;

endmodule

// File: tb/tb_build_huffman_tree.sv
// Self-checking bench for build_huffman_tree: directed table, corner sequences, random builds.
module tb_build_huffman_tree;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  state;
    logic [5:0]  freq_1, freq_2, freq_3, freq_4;
    logic [12:0] info_node_1, info_node_2, info_node_3, info_node_4;
    logic [12:0] info_node_5, info_node_6, info_node_7;
    logic        done;

    logic [12:0] out_s [7];
    logic [12:0] exp_nodes [7];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [5:0]       f1, f2, f3, f4;
        logic [6:0][12:0] nodes;
    } vec_t;

    vec_t tbl [3];

    build_huffman_tree dut (
        .CLK(CLK), .nRST(nRST), .state(state),
        .freq_1(freq_1), .freq_2(freq_2), .freq_3(freq_3), .freq_4(freq_4),
        .info_node_1(info_node_1), .info_node_2(info_node_2), .info_node_3(info_node_3),
        .info_node_4(info_node_4), .info_node_5(info_node_5), .info_node_6(info_node_6),
        .info_node_7(info_node_7), .done(done)
    );

    assign out_s[0] = info_node_1;
    assign out_s[1] = info_node_2;
    assign out_s[2] = info_node_3;
    assign out_s[3] = info_node_4;
    assign out_s[4] = info_node_5;
    assign out_s[5] = info_node_6;
    assign out_s[6] = info_node_7;

    always #5 CLK = ~CLK;

    function automatic logic [12:0] nd(input logic [3:0] p, input logic b, input logic [7:0] w);
        return {p, b, w};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic check_nodes(input string tag);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("%s n%0d", tag, i + 1), {19'd0, out_s[i]}, {19'd0, exp_nodes[i]});
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("%s n%0d zero", tag, i + 1), {19'd0, out_s[i]}, 32'd0);
        end
        check($sformatf("%s done", tag), {31'd0, done}, 32'd0);
    endtask

    // Reference: repeatedly sort active nodes by (weight, index) and merge the two smallest
    task automatic model(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                         input logic [5:0] d);
        int w [7];
        int par [7];
        int br [7];
        bit act [7];
        int keys [$];
        int lo, hi;
        for (int i = 0; i < 7; i++) begin
            w[i] = 0; par[i] = 0; br[i] = 0; act[i] = 1'b0;
        end
        w[0] = int'(a); w[1] = int'(b); w[2] = int'(c); w[3] = int'(d);
        for (int i = 0; i < 4; i++) act[i] = 1'b1;
        for (int m = 0; m < 3; m++) begin
            keys.delete();
            for (int i = 0; i < 7; i++) if (act[i]) keys.push_back(w[i] * 8 + i);
            keys.sort();
            lo = keys[0] % 8;
            hi = keys[1] % 8;
            par[lo] = 5 + m; br[lo] = 0;
            par[hi] = 5 + m; br[hi] = 1;
            act[lo] = 1'b0; act[hi] = 1'b0;
            w[4 + m] = w[lo] + w[hi];
            act[4 + m] = 1'b1;
        end
        par[6] = 15; br[6] = 1;
        for (int i = 0; i < 7; i++) exp_nodes[i] = nd(4'(par[i]), 1'(br[i]), 8'(w[i]));
    endtask

    // Full build with latency, hold, code-phase retention and freq-ignore checks
    task automatic run_build(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                             input logic [5:0] d, input string tag);
        @(negedge CLK);
        freq_1 = a; freq_2 = b; freq_3 = c; freq_4 = d;
        state = 2'b01;
        for (int e = 1; e <= 5; e++) begin
            @(posedge CLK); #1;
            if (e == 2) begin
                freq_1 = ~a; freq_2 = ~b; freq_3 = ~c; freq_4 = ~d;
            end
            check($sformatf("%s done edge%0d", tag, e), {31'd0, done}, (e >= 4) ? 32'd1 : 32'd0);
        end
        check_nodes(tag);
        @(negedge CLK);
        state = 2'b10;
        @(posedge CLK); #1;
        check($sformatf("%s done falls", tag), {31'd0, done}, 32'd0);
        freq_1 = 6'd33; freq_2 = 6'd1; freq_3 = 6'd62; freq_4 = 6'd7;
        @(posedge CLK); #1;
        check_nodes({tag, " code-hold"});
    endtask

    initial begin
        nRST = 1'b0; state = 2'b00;
        freq_1 = 6'd0; freq_2 = 6'd0; freq_3 = 6'd0; freq_4 = 6'd0;

        tbl[0].f1 = 6'd10; tbl[0].f2 = 6'd12; tbl[0].f3 = 6'd5; tbl[0].f4 = 6'd20;
        tbl[0].nodes[0] = nd(4'd5, 1'b1, 8'd10);
        tbl[0].nodes[1] = nd(4'd6, 1'b0, 8'd12);
        tbl[0].nodes[2] = nd(4'd5, 1'b0, 8'd5);
        tbl[0].nodes[3] = nd(4'd7, 1'b0, 8'd20);
        tbl[0].nodes[4] = nd(4'd6, 1'b1, 8'd15);
        tbl[0].nodes[5] = nd(4'd7, 1'b1, 8'd27);
        tbl[0].nodes[6] = nd(4'hF, 1'b1, 8'd47);

        tbl[1].f1 = 6'd8; tbl[1].f2 = 6'd8; tbl[1].f3 = 6'd8; tbl[1].f4 = 6'd8;
        tbl[1].nodes[0] = nd(4'd5, 1'b0, 8'd8);
        tbl[1].nodes[1] = nd(4'd5, 1'b1, 8'd8);
        tbl[1].nodes[2] = nd(4'd6, 1'b0, 8'd8);
        tbl[1].nodes[3] = nd(4'd6, 1'b1, 8'd8);
        tbl[1].nodes[4] = nd(4'd7, 1'b0, 8'd16);
        tbl[1].nodes[5] = nd(4'd7, 1'b1, 8'd16);
        tbl[1].nodes[6] = nd(4'hF, 1'b1, 8'd32);

        tbl[2].f1 = 6'd63; tbl[2].f2 = 6'd63; tbl[2].f3 = 6'd63; tbl[2].f4 = 6'd63;
        tbl[2].nodes[0] = nd(4'd5, 1'b0, 8'd63);
        tbl[2].nodes[1] = nd(4'd5, 1'b1, 8'd63);
        tbl[2].nodes[2] = nd(4'd6, 1'b0, 8'd63);
        tbl[2].nodes[3] = nd(4'd6, 1'b1, 8'd63);
        tbl[2].nodes[4] = nd(4'd7, 1'b0, 8'd126);
        tbl[2].nodes[5] = nd(4'd7, 1'b1, 8'd126);
        tbl[2].nodes[6] = nd(4'hF, 1'b1, 8'd252);

        // Reset state
        #1;
        check_zero("reset");
        @(posedge CLK); #1;
        check_zero("reset held");
        @(negedge CLK);
        nRST = 1'b1;

        // Directed table
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 7; i++) exp_nodes[i] = tbl[t].nodes[i];
            run_build(tbl[t].f1, tbl[t].f2, tbl[t].f3, tbl[t].f4, $sformatf("tbl%0d", t));
        end

        // Abort after the first merge
        @(negedge CLK);
        state = 2'b00;
        @(negedge CLK);
        freq_1 = 6'd9; freq_2 = 6'd4; freq_3 = 6'd17; freq_4 = 6'd2;
        state = 2'b01;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        state = 2'b00;
        @(posedge CLK); #1;
        check_zero("abort");
        model(6'd1, 6'd2, 6'd3, 6'd4);
        run_build(6'd1, 6'd2, 6'd3, 6'd4, "after-abort");
        check("after-abort root weight", {24'd0, info_node_7[7:0]}, 32'd10);

        // Asynchronous reset mid-merge
        @(negedge CLK);
        state = 2'b00;
        @(negedge CLK);
        freq_1 = 6'd30; freq_2 = 6'd11; freq_3 = 6'd11; freq_4 = 6'd0;
        state = 2'b01;
        @(posedge CLK);
        @(posedge CLK); #2;
        nRST = 1'b0;
        #1;
        check_zero("async reset");
        @(negedge CLK);
        nRST = 1'b1;
        state = 2'b00;
        model(6'd30, 6'd11, 6'd11, 6'd0);
        run_build(6'd30, 6'd11, 6'd11, 6'd0, "post-reset");

        // Randomized builds against the reference model; narrow ranges provoke ties
        for (int r = 0; r < 20; r++) begin
            logic [5:0] ra, rb, rc, rd;
            int span;
            span = (r % 2 == 0) ? 63 : 3;
            ra = 6'($urandom_range(0, span));
            rb = 6'($urandom_range(0, span));
            rc = 6'($urandom_range(0, span));
            rd = 6'($urandom_range(0, span));
            model(ra, rb, rc, rd);
            @(negedge CLK);
            state = 2'b00;
            run_build(ra, rb, rc, rd, $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
